// File: rtl/display_scan_ctrl_pkg.sv
// display_scan_ctrl_pkg: segment patterns, scan FSM encoding and blank-mask helper
package display_scan_ctrl_pkg;
  typedef enum logic {ST_GUARD = 1'b0, ST_ON = 1'b1} state_t;
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] SEG_A = 8'h88;
  localparam logic [7:0] SEG_B = 8'h83;
  localparam logic [7:0] SEG_C = 8'hC6;
  localparam logic [7:0] SEG_D = 8'hA1;
  localparam logic [7:0] SEG_E = 8'h86;
  localparam logic [7:0] SEG_F = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEL_OFF = 8'hFF;
  // Forced blanks plus leading zeros from digit 7 down; digit 0 always survives suppression.
  function automatic logic [7:0] eff_blank(input logic [31:0] d, input logic [7:0] b, input logic lz);
    logic [7:0] m;
    logic lead;
    m = b;
    lead = lz;
    for (int k = 7; k >= 1; k--) begin
      if (lead && d[4*k +: 4] == 4'h0) m[k] = 1'b1;
      else lead = 1'b0;
    end
    return m;
  endfunction
endpackage

// File: rtl/display_scan_ctrl_seg7_decode.sv
// seg7_decode: hex digit to active-low {dp,g,f,e,d,c,b,a}, dp always off
module seg7_decode
  import display_scan_ctrl_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [7:0] o_seg
);
  // Pure lookup of the sixteen hex glyphs.
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_hex)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      default: o_seg = SEG_F;
    endcase
  end
endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 8-digit multiplexed 7-segment scanner with frame-synchronous updates
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int CLK_DIV   = 50000,
  parameter int GUARD_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        upd_req,
  input  logic [31:0] upd_data,
  input  logic [7:0]  upd_blank,
  input  logic        lz_en,
  output logic        upd_ack,
  output logic [7:0]  sel,
  output logic [7:0]  seg,
  output logic        frame_start
);
  localparam int CMAX = (CLK_DIV > GUARD_CYC) ? CLK_DIV : GUARD_CYC;
  localparam int CW = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] G_LAST = CW'(GUARD_CYC - 1);
  localparam logic [CW-1:0] O_LAST = CW'(CLK_DIV - 1);
  state_t r_state, w_nstate;
  logic [CW-1:0] r_cnt, w_ncnt;
  logic [2:0] r_idx, w_nidx;
  logic w_last, w_wrap;
  logic [31:0] r_digits;
  logic [7:0] r_blank, w_blank, w_dec;
  logic r_lz;
  logic [3:0] w_hex;
  logic [7:0] r_sel, r_seg;
  logic r_ack, r_fs;
  seg7_decode u_dec (.i_hex(w_hex), .o_seg(w_dec));
  // Next scan position; outputs are registered from it so sel/seg track the state register.
  always_comb begin
    w_last = (r_state == ST_GUARD) ? (r_cnt == G_LAST) : (r_cnt == O_LAST);
    w_wrap = (r_state == ST_ON) && w_last && (r_idx == 3'd7);
    w_nstate = w_last ? ((r_state == ST_GUARD) ? ST_ON : ST_GUARD) : r_state;
    w_ncnt = w_last ? '0 : r_cnt + 1'b1;
    w_nidx = (r_state == ST_ON && w_last) ? r_idx + 3'd1 : r_idx;
    w_hex = r_digits[4*w_nidx +: 4];
    w_blank = eff_blank(r_digits, r_blank, r_lz);
  end
  // Scan state, dwell counter and digit index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_GUARD;
      r_cnt <= '0;
      r_idx <= 3'd0;
    end else begin
      r_state <= w_nstate;
      r_cnt <= w_ncnt;
      r_idx <= w_nidx;
    end
  end
  // Registered drive; ack lands on the first guard cycle after the wrap, frame_start on digit 0 ON entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel <= SEL_OFF;
      r_seg <= SEG_BLANK;
      r_ack <= 1'b0;
      r_fs <= 1'b0;
    end else begin
      r_sel <= (w_nstate == ST_ON) ? ~(8'h01 << w_nidx) : SEL_OFF;
      r_seg <= (w_nstate == ST_ON && !w_blank[w_nidx]) ? w_dec : SEG_BLANK;
      r_ack <= w_wrap && upd_req;
      r_fs <= (r_state == ST_GUARD) && w_last && (r_idx == 3'd0);
    end
  end
  // Shadow frame only changes at the wrap so a frame is never torn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_digits <= 32'h0;
      r_blank <= 8'hFF;
      r_lz <= 1'b0;
    end else if (w_wrap && upd_req) begin
      r_digits <= upd_data;
      r_blank <= upd_blank;
      r_lz <= lz_en;
    end
  end
  assign sel = r_sel;
  assign seg = r_seg;
  assign upd_ack = r_ack;
  assign frame_start = r_fs;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed checks of scan timing, frame loads, blanking and reset
module tb_display_scan_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic upd_req = 1'b0;
  logic [31:0] upd_data = 32'h0;
  logic [7:0] upd_blank = 8'h0;
  logic lz_en = 1'b0;
  logic upd_ack, frame_start;
  logic [7:0] sel, seg;
  int cmp = 0;
  int bad = 0;
  int pc = 0;
  display_scan_ctrl #(.CLK_DIV(4), .GUARD_CYC(1)) dut (
    .clk(clk), .rst(rst), .upd_req(upd_req), .upd_data(upd_data), .upd_blank(upd_blank),
    .lz_en(lz_en), .upd_ack(upd_ack), .sel(sel), .seg(seg), .frame_start(frame_start)
  );
  always #5 clk = ~clk;
  // Edges since reset release: 0 is the opening guard of digit 0, 40k+1 is digit 0 ON.
  always @(posedge clk or posedge rst) begin
    if (rst) pc <= 0;
    else pc <= pc + 1;
  end
  task automatic wait_p(input int p);
    int n = 0;
    while (pc < p && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (pc != p) begin
      cmp++; bad++;
      $display("FAIL wait_p: at edge %0d, wanted %0d", pc, p);
    end
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    cmp += 4;
    if (sel !== 8'hFF) begin bad++; $display("FAIL reset_sel got %h exp FF", sel); end
    if (seg !== 8'hFF) begin bad++; $display("FAIL reset_seg got %h exp FF", seg); end
    if (upd_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got %b exp 0", upd_ack); end
    if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_fs got %b exp 0", frame_start); end
    rst = 1'b0;
  endtask
  task automatic test_idle_scan;
    logic [7:0] one = 8'h01;
    logic [7:0] es;
    int q;
    for (int p = 0; p <= 80; p++) begin
      wait_p(p);
      q = p % 40;
      es = (q % 5 == 0) ? 8'hFF : ~(one << (q / 5));
      cmp += 4;
      if (sel !== es) begin bad++; $display("FAIL idle_sel p=%0d got %h exp %h", p, sel, es); end
      if (seg !== 8'hFF) begin bad++; $display("FAIL idle_seg p=%0d got %h exp FF", p, seg); end
      if (frame_start !== (q == 1)) begin bad++; $display("FAIL idle_fs p=%0d got %b exp %b", p, frame_start, q == 1); end
      if (upd_ack !== 1'b0) begin bad++; $display("FAIL idle_ack p=%0d got %b exp 0", p, upd_ack); end
    end
  endtask
  // Present a frame at edge s, expect the ack at s+40, then check the whole following frame.
  task automatic do_load(input string nm, input logic [31:0] d, input logic [7:0] b, input logic lz,
                         input logic [7:0] e [8], input int s);
    logic [7:0] one = 8'h01;
    logic [7:0] es, eg;
    int q;
    upd_data = d; upd_blank = b; lz_en = lz; upd_req = 1'b1;
    for (int p = s + 1; p <= s + 40; p++) begin
      wait_p(p);
      cmp++;
      if (upd_ack !== (p == s + 40)) begin bad++; $display("FAIL %s_ack p=%0d got %b exp %b", nm, p, upd_ack, p == s + 40); end
    end
    upd_req = 1'b0;
    upd_data = 32'hFFFFFFFF; upd_blank = 8'h00; lz_en = 1'b0;
    for (int p = s + 41; p <= s + 80; p++) begin
      wait_p(p);
      q = p % 40;
      es = (q % 5 == 0) ? 8'hFF : ~(one << (q / 5));
      eg = (q % 5 == 0) ? 8'hFF : e[q / 5];
      cmp += 3;
      if (sel !== es) begin bad++; $display("FAIL %s_sel p=%0d got %h exp %h", nm, p, sel, es); end
      if (seg !== eg) begin bad++; $display("FAIL %s_seg p=%0d got %h exp %h", nm, p, seg, eg); end
      if (upd_ack !== 1'b0) begin bad++; $display("FAIL %s_ack2 p=%0d got %b exp 0", nm, p, upd_ack); end
    end
  endtask
  task automatic test_load;
    logic [7:0] e [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
    do_load("load", 32'h76543210, 8'h00, 1'b0, e, 80);
  endtask
  task automatic test_lz;
    logic [7:0] e [8] = '{8'h92, 8'hC0, 8'h88, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    do_load("lz", 32'h00000A05, 8'h00, 1'b1, e, 160);
  endtask
  task automatic test_zero;
    logic [7:0] e [8] = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    do_load("zero", 32'h0, 8'h00, 1'b1, e, 240);
  endtask
  task automatic test_blank;
    logic [7:0] e [8] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    do_load("blank", 32'h0, 8'h01, 1'b1, e, 320);
  endtask
  task automatic test_back_to_back;
    logic [7:0] e [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
    logic [7:0] eg;
    int q;
    int acks = 0;
    upd_data = 32'h76543210; upd_blank = 8'h00; lz_en = 1'b0; upd_req = 1'b0;
    for (int p = 401; p <= 440; p++) begin
      wait_p(p);
      cmp += 2;
      if (seg !== 8'hFF) begin bad++; $display("FAIL midframe_seg p=%0d got %h exp FF", p, seg); end
      if (upd_ack !== 1'b0) begin bad++; $display("FAIL midframe_ack p=%0d got %b exp 0", p, upd_ack); end
    end
    upd_req = 1'b1;
    for (int p = 441; p <= 520; p++) begin
      wait_p(p);
      q = p % 40;
      eg = (p <= 480 || q % 5 == 0) ? 8'hFF : e[q / 5];
      if (upd_ack === 1'b1) acks++;
      cmp += 2;
      if (upd_ack !== (p == 480 || p == 520)) begin bad++; $display("FAIL b2b_ack p=%0d got %b exp %b", p, upd_ack, p == 480 || p == 520); end
      if (seg !== eg) begin bad++; $display("FAIL b2b_seg p=%0d got %h exp %h", p, seg, eg); end
    end
    cmp++;
    if (acks != 2) begin bad++; $display("FAIL b2b_count got %0d exp 2", acks); end
  endtask
  task automatic test_reset_mid;
    logic [7:0] one = 8'h01;
    logic [7:0] es;
    int q;
    wait_p(542);
    cmp += 2;
    if (sel !== 8'hEF) begin bad++; $display("FAIL rmid_pre_sel got %h exp EF", sel); end
    if (seg !== 8'h99) begin bad++; $display("FAIL rmid_pre_seg got %h exp 99", seg); end
    #2 rst = 1'b1;
    #1;
    cmp += 4;
    if (sel !== 8'hFF) begin bad++; $display("FAIL rmid_sel got %h exp FF", sel); end
    if (seg !== 8'hFF) begin bad++; $display("FAIL rmid_seg got %h exp FF", seg); end
    if (upd_ack !== 1'b0) begin bad++; $display("FAIL rmid_ack got %b exp 0", upd_ack); end
    if (frame_start !== 1'b0) begin bad++; $display("FAIL rmid_fs got %b exp 0", frame_start); end
    upd_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int p = 0; p <= 40; p++) begin
      wait_p(p);
      q = p % 40;
      es = (q % 5 == 0) ? 8'hFF : ~(one << (q / 5));
      cmp += 3;
      if (sel !== es) begin bad++; $display("FAIL rpost_sel p=%0d got %h exp %h", p, sel, es); end
      if (seg !== 8'hFF) begin bad++; $display("FAIL rpost_seg p=%0d got %h exp FF", p, seg); end
      if (upd_ack !== 1'b0) begin bad++; $display("FAIL rpost_ack p=%0d got %b exp 0", p, upd_ack); end
    end
  endtask
  initial begin
    test_reset;
    test_idle_scan;
    test_load;
    test_lz;
    test_zero;
    test_blank;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
